// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared constants and helpers for the convolution datapath.
//  Revision    : 1.0  initial release
// ============================================================================

package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 48;
  localparam int DEF_MUL_STAGES = 2;

  // Sideband bit positions within the per-beat control vector
  localparam int SB_SIGNED = 0;
  localparam int SB_ACC    = 1;
  localparam int SB_FIRST  = 2;
  localparam int SB_LAST   = 3;
  localparam int SB_WIDTH  = 4;

  function automatic logic [SB_WIDTH-1:0] pack_sb(
    input logic sgn,
    input logic acc,
    input logic first,
    input logic last
  );
    logic [SB_WIDTH-1:0] sb;
    sb            = '0;
    sb[SB_SIGNED] = sgn;
    sb[SB_ACC]    = acc;
    sb[SB_FIRST]  = first;
    sb[SB_LAST]   = last;
    return sb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pipe
//  Description : Operand register followed by MUL_STAGES product registers,
//                all advancing together under a single global enable.
//  Revision    : 1.0  initial release
// ============================================================================

module mult_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   a_i,
  input  logic [DATA_WIDTH-1:0]   b_i,
  input  logic [SB_WIDTH-1:0]     sb_i,
  output logic                    valid_o,
  output logic [2*DATA_WIDTH-1:0] prod_o,
  output logic [SB_WIDTH-1:0]     sb_o
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                  opnd_vld_q;
  logic [DATA_WIDTH-1:0] opnd_a_q;
  logic [DATA_WIDTH-1:0] opnd_b_q;
  logic [SB_WIDTH-1:0]   opnd_sb_q;

  logic [PW-1:0]         w_a_ext;
  logic [PW-1:0]         w_b_ext;
  logic [PW-1:0]         w_prod;

  logic                  vld_q  [MUL_STAGES];
  logic [PW-1:0]         prod_q [MUL_STAGES];
  logic [SB_WIDTH-1:0]   sb_q   [MUL_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_vld_q <= 1'b0;
      opnd_a_q   <= '0;
      opnd_b_q   <= '0;
      opnd_sb_q  <= '0;
    end else if (en_i) begin
      opnd_vld_q <= valid_i;
      opnd_a_q   <= a_i;
      opnd_b_q   <= b_i;
      opnd_sb_q  <= sb_i;
    end
  end

  // Extending both operands to 2*DATA_WIDTH makes a single truncated
  // multiply exact for either signedness, since the true product fits.
  assign w_a_ext = {{DATA_WIDTH{opnd_sb_q[SB_SIGNED] & opnd_a_q[DATA_WIDTH-1]}}, opnd_a_q};
  assign w_b_ext = {{DATA_WIDTH{opnd_sb_q[SB_SIGNED] & opnd_b_q[DATA_WIDTH-1]}}, opnd_b_q};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < MUL_STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        prod_q[s] <= '0;
        sb_q[s]   <= '0;
      end
    end else if (en_i) begin
      vld_q[0]  <= opnd_vld_q;
      prod_q[0] <= w_prod;
      sb_q[0]   <= opnd_sb_q;
      for (int s = 1; s < MUL_STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        prod_q[s] <= prod_q[s-1];
        sb_q[s]   <= sb_q[s-1];
      end
    end
  end

  assign valid_o = vld_q[MUL_STAGES-1];
  assign prod_o  = prod_q[MUL_STAGES-1];
  assign sb_o    = sb_q[MUL_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pipe
//  Description : Handshaked signed/unsigned multiply with optional
//                dot-product accumulation and full output backpressure.
//  Revision    : 1.0  initial release
// ============================================================================

module mac_pipe
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_signed,
  input  logic                  in_acc,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data
);

  localparam int PW = 2 * DATA_WIDTH;

  logic                 w_stall;
  logic                 w_pvalid;
  logic [PW-1:0]        w_prod;
  logic [SB_WIDTH-1:0]  w_sb;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_acc_new;

  logic [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [ACC_WIDTH-1:0] out_data_q,  out_data_d;
  logic                 out_valid_q, out_valid_d;

  // Downstream backpressure freezes the whole pipe, so in_ready depends
  // combinationally on out_ready.
  assign w_stall  = out_valid_q & ~out_ready;
  assign in_ready = ~w_stall;

  mult_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .MUL_STAGES (MUL_STAGES)
  ) u_mult_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (~w_stall),
    .valid_i (in_valid),
    .a_i     (in_a),
    .b_i     (in_b),
    .sb_i    (pack_sb(in_signed, in_acc, in_first, in_last)),
    .valid_o (w_pvalid),
    .prod_o  (w_prod),
    .sb_o    (w_sb)
  );

  generate
    if (ACC_WIDTH > PW) begin : g_ext_wide
      assign w_ext = {{(ACC_WIDTH-PW){w_sb[SB_SIGNED] & w_prod[PW-1]}}, w_prod};
    end else begin : g_ext_none
      assign w_ext = w_prod;
    end
  endgenerate

  assign w_acc_new = w_sb[SB_FIRST] ? w_ext : (acc_q + w_ext);

  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (!w_stall) begin
      out_valid_d = 1'b0;
      if (w_pvalid) begin
        if (!w_sb[SB_ACC]) begin
          out_data_d  = w_ext;
          out_valid_d = 1'b1;
        end else begin
          acc_d = w_acc_new;
          if (w_sb[SB_LAST]) begin
            out_data_d  = w_acc_new;
            out_valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_pipe
//  Description : Directed scoreboard bench for mac_pipe (8x8 -> 16 bit, 2 stages).
//  Revision    : 1.0  initial release
// ============================================================================

module tb_mac_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic        in_acc;
  logic        in_first;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  typedef struct {
    logic [15:0] data;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  bit          lat_en   = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_data  = '0;

  mac_pipe #(
    .DATA_WIDTH (8),
    .ACC_WIDTH  (16),
    .MUL_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_acc    (in_acc),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks hold-during-stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_data_stable", {16'd0, out_data}, {16'd0, prev_data});
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && !out_ready)
        chk("in_ready_low_in_stall", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        n_checks++;
        assert (sb_q.size() > 0) else begin
          n_fail++;
          $error("FAIL unexpected_output: observed %0h expected no output", out_data);
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("result", {16'd0, out_data}, {16'd0, e.data});
          if (e.lat) chk("latency_cycle", cyc, e.cyc);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit sg, input bit ac,
                      input bit fi, input bit la, input bit push, input logic [15:0] expv);
    int t;
    bit done;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = sg;
    in_acc    = ac;
    in_first  = fi;
    in_last   = la;
    done = 1'b0;
    t    = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        if (push) sb_q.push_back('{expv, cyc + 4, lat_en});
        done = 1'b1;
      end
      @(posedge clk);
      t++;
    end
    chk("send_accept_timeout", {31'd0, done}, 32'd1);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_pending", sb_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    in_acc    = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {16'd0, out_data}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back pass-through products
    send(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd65025);
    send(8'h80, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd16384);
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    drain();

    // Signed 4-beat run: 12 - 10 + 49 - 1
    send(8'd3,  8'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(8'hFE, 8'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send(8'd7,  8'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send(8'd1,  8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'd50);
    drain();

    // Backpressure over a 10-beat stream
    lat_en = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(8'(i + 1), 8'(i + 3), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'((i + 1) * (i + 3)));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    lat_en = 1'b1;

    // Pass-through interleaved inside a run
    send(8'd2, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(8'd9, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd81);
    send(8'd3, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd13);
    drain();

    // Wrap, single-beat run, continuation without first
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd64514);
    send(8'hFD, 8'd5,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFF1);
    send(8'd2,  8'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'hFFF5);
    drain();

    // Partial sum plus stalled in-flight beats, then asynchronous reset
    send(8'd1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send(8'd2, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send(8'd3, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    drain();
    send(8'd5, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd25);
    send(8'd4, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send(8'd6, 8'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    out_ready = 1'b0;
    send(8'd7, 8'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_reset_out_data", {16'd0, out_data}, 32'd0);
    chk("async_reset_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(8'd2, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    send(8'd4, 8'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd26);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_pipe.md
# mac_pipe

Parametrised, handshaked successor to the fixed two-stage multiplier in the convolution datapath. It multiplies DATA_WIDTH-bit operands in signed or unsigned mode through a configurable number of register stages. It then either emits each product or accumulates a run of products into one ACC_WIDTH-bit dot-product result. It sits between the window/weight fetch logic and the PE output buffer, and supports full valid/ready backpressure.

## Interface
- DATA_WIDTH, 16: operand width, ≥2.
- ACC_WIDTH, 48: result/accumulator width, ≥2*DATA_WIDTH.
- MUL_STAGES, 2: product register stages, ≥1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a, in_b  in  DATA_WIDTH each  operands.
- in_signed  in  1  1: two's-complement operands, 0: unsigned.
- in_acc  in  1  1: beat belongs to an accumulate run, 0: pass-through product.
- in_first  in  1  acc run start; clear the sum before adding this product.
- in_last  in  1  acc run end; emit the sum including this product.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_WIDTH  result.

## Operation
- Beat accepted when in_valid && in_ready. in_signed, in_acc, in_first and in_last travel with the beat as sideband.
- Product: full 2*DATA_WIDTH product, computed signed or unsigned per beat, then sign- or zero-extended to ACC_WIDTH.
- Final stage (accumulate/output register), for a valid beat:
  - in_acc=0: out_data ← product, out_valid ← 1. Accumulator untouched.
  - in_acc=1, in_first=1: acc ← product. Otherwise acc ← acc + product. Arithmetic is modulo 2^ACC_WIDTH (wrap, no saturation, no flag).
  - in_acc=1, in_last=1: out_data ← the new acc value, out_valid ← 1.
  - in_acc=1, in_last=0: no output is produced.
- in_first && in_last on the same beat: result equals that product.
- An acc beat without a preceding first adds onto the current accumulator.
- Interleaved in_acc=0 beats do not disturb a run in progress.
- Bubbles (invalid stage slots) never change acc or out_data.
- Flow control: global stall = out_valid && !out_ready.
  - During a stall every pipeline register, including acc, holds.
  - in_ready = !stall. This is a combinational path from out_ready; it is intentional.
- When not stalled, out_valid clears after handshake unless a new result arrives in the same cycle.
- Reset (rst_n low, any time, including mid-run): all stage valid bits 0, acc 0, out_valid 0, out_data 0. In-flight beats are discarded. in_ready is 1 after reset.

## Timing
- Latency, no stall: beat accepted at edge N → out_valid high after edge N+MUL_STAGES+1. Default: 3 cycles.
- Throughput: 1 beat/cycle when out_ready is held high.
- An acc run of K beats produces one result, MUL_STAGES+1 cycles after its last beat is accepted.
- out_data and out_valid are stable while out_valid && !out_ready.
- No combinational path from in_* to out_*.

## Structure
- Shared package `conv_pkg`:
  - sideband field positions (SIGNED, ACC, FIRST, LAST) and sideband width constant;
  - default DATA_WIDTH and ACC_WIDTH.
- Sub-module `mult_pipe`: MUL_STAGES-deep product pipeline with global enable. It carries product, stage valid and sideband, and resets asynchronously to zero.
- The top level holds the accumulate/output register, the stall logic and the handshake.

## Test plan
- Pass-through, DATA_WIDTH=8, MUL_STAGES=2: unsigned 255×255 → 65025; signed 0x80×0x80 → 16384; signed 0xFF×0x01 → −1 sign-extended. Each appears 3 cycles after acceptance, back-to-back.
- Acc run, signed, 4 beats (3×4, −2×5, 7×7, 1×−1, first on beat 1, last on beat 4) → single result 50. No out_valid for beats 1–3.
- Backpressure: out_ready low for 5 cycles during a stream of 10 pass-through beats → in_ready low while stalled, no beat lost or duplicated, results in order, out_data stable throughout the stall.
- Mixed: acc run 2×2 (first), pass-through 9×9, 3×3 (last) → outputs 81 then 13, in that order.
- Wrap/edges: ACC_WIDTH=16, DATA_WIDTH=8, unsigned run of two 255×255 → (130050 mod 65536)=64514. A single beat with first=last=1 returns its product. An acc beat without first adds onto the previous sum.
- Reset mid-run: assert rst_n low with 3 beats in flight and a partial sum → out_valid 0 immediately. After release, a new run starting without first sums from 0.
